sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter_pkg.sv | 29 ++
 rtl/sram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_arbiter_pkg
// Shared constants for the external async SRAM arbiter: bus widths, default
// strobe timing and the FSM state encoding. The testbench SRAM bus model uses
// the same widths and cycle counts.
// -----------------------------------------------------------------------------
package sram_arbiter_pkg;

    localparam int SRAM_ADDR_WIDTH   = 20;
    localparam int SRAM_DATA_WIDTH   = 24;

    localparam int DEF_READ_CYCLES   = 2;
    localparam int DEF_WRITE_CYCLES  = 2;
    localparam int DEF_VID_BURST_MAX = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_RD       = 3'd1;
    localparam state_t ST_WR_SETUP = 3'd2;
    localparam state_t ST_WR_PULSE = 3'd3;
    localparam state_t ST_WR_HOLD  = 3'd4;
    localparam state_t ST_TURN     = 3'd5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one external async SRAM between a high-priority video read port and
// a host read/write port. Generates CS/OE/WE timing, data bus direction and
// turnaround, and limits consecutive video grants while the host waits.
//
// Ports
//   i_master_clk, i_reset      : clock, async active-high reset
//   i_vid_*  / o_vid_*         : video read request/ack, read data + valid
//   i_host_* / o_host_*        : host request (we/addr/wdata), ack, read data
//   o_sram_address/data_out    : SRAM address and write data
//   i_sram_data_in             : SRAM read data
//   o_sram_data_dir_out        : 1 = FPGA drives the data bus
//   o_sram_cs_n/oe_n/we_n      : SRAM strobes, active low
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | arbitrate; grant latches address (and write data)
// RD          | CS+OE low for READ_CYCLES; capture data on the last edge
// WR_SETUP    | CS low, bus driven, WE still high
// WR_PULSE    | WE low for WRITE_CYCLES
// WR_HOLD     | WE high, bus still driven
// TURN        | CS high, bus released before any later OE
// -----------------------------------------------------------------------------
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH    = SRAM_DATA_WIDTH,
    parameter int READ_CYCLES   = DEF_READ_CYCLES,
    parameter int WRITE_CYCLES  = DEF_WRITE_CYCLES,
    parameter int VID_BURST_MAX = DEF_VID_BURST_MAX
) (
    input  logic                  i_master_clk,
    input  logic                  i_reset,

    input  logic                  i_vid_req,
    input  logic [ADDR_WIDTH-1:0] i_vid_addr,
    output logic                  o_vid_ack,
    output logic [DATA_WIDTH-1:0] o_vid_rdata,
    output logic                  o_vid_rdata_valid,

    input  logic                  i_host_req,
    input  logic                  i_host_we,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic [DATA_WIDTH-1:0] i_host_wdata,
    output logic                  o_host_ack,
    output logic [DATA_WIDTH-1:0] o_host_rdata,
    output logic                  o_host_rdata_valid,

    output logic [ADDR_WIDTH-1:0] o_sram_address,
    output logic [DATA_WIDTH-1:0] o_sram_data_out,
    input  logic [DATA_WIDTH-1:0] i_sram_data_in,
    output logic                  o_sram_data_dir_out,
    output logic                  o_sram_cs_n,
    output logic                  o_sram_oe_n,
    output logic                  o_sram_we_n
);

    localparam int PH_MAX = max_int(READ_CYCLES, WRITE_CYCLES);
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int BC_W   = $clog2(VID_BURST_MAX + 1);

    localparam logic [PH_W-1:0] RD_LOAD   = PH_W'(READ_CYCLES - 1);
    localparam logic [PH_W-1:0] WR_LOAD   = PH_W'(WRITE_CYCLES - 1);
    localparam logic [BC_W-1:0] BURST_TOP = BC_W'(VID_BURST_MAX);

    state_t          r_state;
    logic [PH_W-1:0] r_phase;
    logic [BC_W-1:0] r_burst_cnt;
    logic            r_owner_host;

    logic            w_idle;
    logic            w_vid_win;
    logic            w_host_win;

    // Video keeps priority until it has taken VID_BURST_MAX grants in a row
    // while the host was waiting; then the host gets exactly one slot.
    assign w_idle     = (r_state == ST_IDLE);
    assign w_vid_win  = i_vid_req && !(i_host_req && (r_burst_cnt == BURST_TOP));
    assign w_host_win = i_host_req && !w_vid_win;

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state             <= ST_IDLE;
            r_phase             <= '0;
            r_burst_cnt         <= '0;
            r_owner_host        <= 1'b0;
            o_vid_ack           <= 1'b0;
            o_vid_rdata         <= '0;
            o_vid_rdata_valid   <= 1'b0;
            o_host_ack          <= 1'b0;
            o_host_rdata        <= '0;
            o_host_rdata_valid  <= 1'b0;
            o_sram_address      <= '0;
            o_sram_data_out     <= '0;
            o_sram_data_dir_out <= 1'b0;
            o_sram_cs_n         <= 1'b1;
            o_sram_oe_n         <= 1'b1;
            o_sram_we_n         <= 1'b1;
        end else begin
            o_vid_ack          <= 1'b0;
            o_host_ack         <= 1'b0;
            o_vid_rdata_valid  <= 1'b0;
            o_host_rdata_valid <= 1'b0;

            // Burst counter only means something while the host is waiting.
            if (!i_host_req) begin
                r_burst_cnt <= '0;
            end else if (w_idle && w_host_win) begin
                r_burst_cnt <= '0;
            end else if (w_idle && w_vid_win && (r_burst_cnt != BURST_TOP)) begin
                r_burst_cnt <= r_burst_cnt + BC_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_vid_win) begin
                        r_state        <= ST_RD;
                        r_owner_host   <= 1'b0;
                        o_vid_ack      <= 1'b1;
                        o_sram_address <= i_vid_addr;
                        o_sram_cs_n    <= 1'b0;
                        o_sram_oe_n    <= 1'b0;
                        r_phase        <= RD_LOAD;
                    end else if (w_host_win) begin
                        r_owner_host   <= 1'b1;
                        o_host_ack     <= 1'b1;
                        o_sram_address <= i_host_addr;
                        o_sram_cs_n    <= 1'b0;
                        if (i_host_we) begin
                            r_state             <= ST_WR_SETUP;
                            o_sram_data_out     <= i_host_wdata;
                            o_sram_data_dir_out <= 1'b1;
                        end else begin
                            r_state     <= ST_RD;
                            o_sram_oe_n <= 1'b0;
                            r_phase     <= RD_LOAD;
                        end
                    end
                end

                ST_RD: begin
                    if (r_phase == '0) begin
                        if (r_owner_host) begin
                            o_host_rdata       <= i_sram_data_in;
                            o_host_rdata_valid <= 1'b1;
                        end else begin
                            o_vid_rdata       <= i_sram_data_in;
                            o_vid_rdata_valid <= 1'b1;
                        end
                        o_sram_cs_n <= 1'b1;
                        o_sram_oe_n <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_phase <= r_phase - PH_W'(1);
                    end
                end

                ST_WR_SETUP: begin
                    o_sram_we_n <= 1'b0;
                    r_phase     <= WR_LOAD;
                    r_state     <= ST_WR_PULSE;
                end

                ST_WR_PULSE: begin
                    if (r_phase == '0) begin
                        o_sram_we_n <= 1'b1;
                        r_state     <= ST_WR_HOLD;
                    end else begin
                        r_phase <= r_phase - PH_W'(1);
                    end
                end

                ST_WR_HOLD: begin
                    // Release the bus here so TURN is a full cycle with
                    // nobody driving before any following OE.
                    o_sram_cs_n         <= 1'b1;
                    o_sram_data_dir_out <= 1'b0;
                    r_state             <= ST_TURN;
                end

                ST_TURN: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    o_sram_cs_n         <= 1'b1;
                    o_sram_oe_n         <= 1'b1;
                    o_sram_we_n         <= 1'b1;
                    o_sram_data_dir_out <= 1'b0;
                    r_state             <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int AW  = SRAM_ADDR_WIDTH;
    localparam int DW  = SRAM_DATA_WIDTH;
    localparam int RC  = DEF_READ_CYCLES;
    localparam int WC  = DEF_WRITE_CYCLES;
    localparam int BM  = DEF_VID_BURST_MAX;
    localparam int LIM = 200;

    logic          clk;
    logic          rst;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          o_vid_ack;
    logic [DW-1:0] o_vid_rdata;
    logic          o_vid_rdata_valid;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          o_host_ack;
    logic [DW-1:0] o_host_rdata;
    logic          o_host_rdata_valid;
    logic [AW-1:0] o_sram_address;
    logic [DW-1:0] o_sram_data_out;
    logic [DW-1:0] sram_din;
    logic          o_sram_data_dir_out;
    logic          o_sram_cs_n;
    logic          o_sram_oe_n;
    logic          o_sram_we_n;

    sram_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_CYCLES(RC),
        .WRITE_CYCLES(WC), .VID_BURST_MAX(BM)
    ) dut (
        .i_master_clk       (clk),
        .i_reset            (rst),
        .i_vid_req          (vid_req),
        .i_vid_addr         (vid_addr),
        .o_vid_ack          (o_vid_ack),
        .o_vid_rdata        (o_vid_rdata),
        .o_vid_rdata_valid  (o_vid_rdata_valid),
        .i_host_req         (host_req),
        .i_host_we          (host_we),
        .i_host_addr        (host_addr),
        .i_host_wdata       (host_wdata),
        .o_host_ack         (o_host_ack),
        .o_host_rdata       (o_host_rdata),
        .o_host_rdata_valid (o_host_rdata_valid),
        .o_sram_address     (o_sram_address),
        .o_sram_data_out    (o_sram_data_out),
        .i_sram_data_in     (sram_din),
        .o_sram_data_dir_out(o_sram_data_dir_out),
        .o_sram_cs_n        (o_sram_cs_n),
        .o_sram_oe_n        (o_sram_oe_n),
        .o_sram_we_n        (o_sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- SRAM bus model (pins only, indexed by addr[9:0]) ----
    logic [DW-1:0] bus_mem [1024];
    bit            bus_wr  [1024];

    function automatic logic [DW-1:0] mem_init(input logic [9:0] a);
        logic [DW-1:0] v;
        v = {2'b01, a, 2'b10, ~a} ^ 24'h5A5A5A;
        if (a == 10'h010) v = 24'hABCDEF;
        return v;
    endfunction

    function automatic logic [DW-1:0] bus_rd(input logic [9:0] a);
        return bus_wr[a] ? bus_mem[a] : mem_init(a);
    endfunction

    always @(negedge clk)
        sram_din <= (!o_sram_cs_n && !o_sram_oe_n) ? bus_rd(o_sram_address[9:0]) : 24'hEE0BAD;

    always @(posedge clk)
        if (!rst && !o_sram_cs_n && !o_sram_we_n && o_sram_data_dir_out) begin
            bus_mem[o_sram_address[9:0]] <= o_sram_data_out;
            bus_wr[o_sram_address[9:0]]  <= 1'b1;
        end

    // ---------------- transaction-level reference ----------------
    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] vid_q[$];
    logic [DW-1:0] host_q[$];
    int            burst_log[$];
    longint        vid_t, host_t;
    int            vid_n;

    task automatic monitor();
        int   oe_run = 0;
        int   we_run = 0;
        int   wait_cnt = 0;
        logic prev_dir = 1'b0;
        logic h_edge;
        forever begin
            @(posedge clk);
            h_edge = host_req;
            #1;
            if (rst) begin
                oe_run = 0; we_run = 0; wait_cnt = 0; prev_dir = 1'b0;
            end else begin
                check_eq("oe_we_overlap", (!o_sram_oe_n && !o_sram_we_n), 1'b0);
                if (!o_sram_we_n) check_eq("we_needs_dir", o_sram_data_dir_out, 1'b1);
                if (!o_sram_oe_n) begin
                    check_eq("oe_after_dir", prev_dir, 1'b0);
                    check_eq("oe_needs_cs", o_sram_cs_n, 1'b0);
                end
                if (!o_sram_oe_n) oe_run++;
                else if (oe_run != 0) begin check_eq("oe_len", oe_run, RC); oe_run = 0; end
                if (!o_sram_we_n) we_run++;
                else if (we_run != 0) begin check_eq("we_len", we_run, WC); we_run = 0; end
                if (o_vid_ack && h_edge) wait_cnt++;
                if (o_host_ack) begin
                    check_eq("host_starved", wait_cnt > BM, 1'b0);
                    burst_log.push_back(wait_cnt);
                    wait_cnt = 0;
                end
                if (o_vid_rdata_valid) begin
                    check_eq("vid_q_nonempty", vid_q.size() > 0, 1'b1);
                    if (vid_q.size() > 0) check_eq("vid_rdata", o_vid_rdata, vid_q.pop_front());
                end
                if (o_host_rdata_valid) begin
                    check_eq("host_q_nonempty", host_q.size() > 0, 1'b1);
                    if (host_q.size() > 0) check_eq("host_rdata", o_host_rdata, host_q.pop_front());
                end
                prev_dir = o_sram_data_dir_out;
            end
        end
    endtask

    task automatic vid_read(input logic [AW-1:0] a);
        int n = 0;
        vid_req  = 1'b1;
        vid_addr = a;
        do begin @(posedge clk); #1; n++; end while (!o_vid_ack && n < LIM);
        check_eq("vid_ack_seen", o_vid_ack, 1'b1);
        if (o_vid_ack) begin
            vid_q.push_back(ref_mem[a[9:0]]);
            vid_t = $time;
            vid_n = n;
        end
        vid_req = 1'b0;
    endtask

    task automatic host_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        do begin @(posedge clk); #1; n++; end while (!o_host_ack && n < LIM);
        check_eq("host_ack_seen", o_host_ack, 1'b1);
        if (o_host_ack) begin
            if (we) ref_mem[a[9:0]] = d;
            else    host_q.push_back(ref_mem[a[9:0]]);
            host_t = $time;
        end
        host_req = 1'b0;
    endtask

    task automatic wait_vid_valid(output int m, output int oc);
        m  = 0;
        oc = (!o_sram_oe_n) ? 1 : 0;
        do begin
            @(posedge clk); #1; m++;
            if (!o_sram_oe_n) oc++;
        end while (!o_vid_rdata_valid && m < LIM);
        check_eq("vid_valid_seen", o_vid_rdata_valid, 1'b1);
    endtask

    task automatic wait_host_valid(output int m);
        m = 0;
        do begin @(posedge clk); #1; m++; end while (!o_host_rdata_valid && m < LIM);
        check_eq("host_valid_seen", o_host_rdata_valid, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int m, oc, dz, c;
        logic [3:0] exp_pins;
        rst = 1'b1; vid_req = 1'b0; vid_addr = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem_init(10'(i));
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pins", {o_sram_cs_n, o_sram_oe_n, o_sram_we_n, o_sram_data_dir_out}, 4'b1110);
        check_eq("rst_addr", o_sram_address, 0);
        check_eq("rst_dout", o_sram_data_out, 0);
        check_eq("rst_pulses", {o_vid_ack, o_vid_rdata_valid, o_host_ack, o_host_rdata_valid}, 0);
        check_eq("rst_rdata", {o_vid_rdata, o_host_rdata}, 0);
        rst = 1'b0;

        // single video read
        vid_read(20'h00010);
        check_eq("t1_ack_lat", vid_n, 1);
        wait_vid_valid(m, oc);
        check_eq("t1_valid_lat", m, RC);
        check_eq("t1_oe_cycles", oc, RC);
        check_eq("t1_rdata", o_vid_rdata, 24'hABCDEF);

        // host write, pin sequence, read-back
        host_access(1'b1, 20'hFFFFF, 24'h123456);
        check_eq("t2_addr", o_sram_address, 20'hFFFFF);
        check_eq("t2_dout", o_sram_data_out, 24'h123456);
        for (int j = 0; j < WC + 4; j++) begin
            if (j == 0)           exp_pins = 4'b0111;
            else if (j <= WC)     exp_pins = 4'b0101;
            else if (j == WC + 1) exp_pins = 4'b0111;
            else                  exp_pins = 4'b1110;
            check_eq($sformatf("t2_pins_%0d", j),
                     {o_sram_cs_n, o_sram_oe_n, o_sram_we_n, o_sram_data_dir_out}, exp_pins);
            @(posedge clk); #1;
        end
        check_eq("t2_bus_mem", bus_mem[10'h3FF], 24'h123456);
        host_access(1'b0, 20'hFFFFF, '0);
        wait_host_valid(m);
        check_eq("t2_host_lat", m, RC);
        check_eq("t2_readback", o_host_rdata, 24'h123456);

        // simultaneous requests
        fork
            vid_read(20'h00020);
            host_access(1'b0, 20'h00030, '0);
        join
        check_eq("t3_vid_first", vid_t < host_t, 1'b1);
        check_eq("t3_host_next", (host_t - vid_t) / 10, RC + 1);
        repeat (8) begin @(posedge clk); #1; end

        // continuous video with host pending
        burst_log.delete();
        fork
            for (int k = 0; k < 20; k++) vid_read(20'(32'h100 + k));
            begin
                host_access(1'b0, 20'h00040, '0);
                host_access(1'b0, 20'h00041, '0);
            end
        join
        check_eq("t4_host_grants", burst_log.size(), 2);
        foreach (burst_log[i]) check_eq($sformatf("t4_burst_%0d", i), burst_log[i], BM);
        repeat (8) begin @(posedge clk); #1; end

        // write followed immediately by video read
        host_access(1'b1, 20'h000AA, 24'h5A5A5A);
        fork
            vid_read(20'h000AA);
            begin
                dz = 0; c = 0;
                while (o_sram_oe_n && c < LIM) begin
                    if (o_sram_data_dir_out) dz = 0; else dz++;
                    @(posedge clk); #1; c++;
                end
                check_eq("t5_turn_gap", dz >= 1, 1'b1);
            end
        join
        wait_vid_valid(m, oc);
        check_eq("t5_rdata", o_vid_rdata, 24'h5A5A5A);

        // reset during write pulse (word 0x055 is left undefined)
        host_access(1'b1, 20'h00055, 24'hCAFE01);
        @(posedge clk); #1;
        check_eq("t6_in_pulse", o_sram_we_n, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_async_pins", {o_sram_cs_n, o_sram_oe_n, o_sram_we_n, o_sram_data_dir_out}, 4'b1110);
        check_eq("t6_async_pulses", {o_vid_ack, o_vid_rdata_valid, o_host_ack, o_host_rdata_valid}, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check_eq("t6_rst_pins", {o_sram_cs_n, o_sram_oe_n, o_sram_we_n, o_sram_data_dir_out}, 4'b1110);
        end
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("t6_quiet", {o_vid_ack, o_vid_rdata_valid, o_host_ack, o_host_rdata_valid}, 0);
        end
        vid_read(20'h00010);
        wait_vid_valid(m, oc);
        check_eq("t6_read_after", o_vid_rdata, 24'hABCDEF);

        // randomized mixed traffic
        fork
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(3)) begin @(posedge clk); #1; end
                vid_read(20'(32'h100 + $urandom_range(255)));
            end
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(3)) begin @(posedge clk); #1; end
                host_access(1'($urandom_range(1)), 20'(32'h100 + $urandom_range(255)), 24'($urandom));
            end
        join
        repeat (10) begin @(posedge clk); #1; end
        check_eq("vid_q_drained", vid_q.size(), 0);
        check_eq("host_q_drained", host_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
